// File: rtl/exec_control_pipe_if.sv
// rtl/exec_control_pipe_if.sv - decode-to-execute control bundle for exec_control_pipe
//
// Carries the decoded control word, hazard-unit controls and Execute ALU flags
// into the pipe, and the per-stage controls, branch strobes and committed flags
// back out.
//   master: decode/hazard side (drives control word, stallE, flushE, ALU flags)
//   slave : exec_control_pipe
interface exec_control_pipe_if #(
    parameter int OPCODEWIDTH  = 4,
    parameter int ALUCTRLWIDTH = 3
);
    logic                    stallE;
    logic                    flushE;
    logic                    validD;
    logic [OPCODEWIDTH-1:0]  opcodeD;
    logic                    writeEnableDD;
    logic                    writeDataEnableMD;
    logic                    resultSelectorWBD;
    logic                    data2SelectorED;
    logic                    outFlagD;
    logic [ALUCTRLWIDTH-1:0] aluControlED;
    logic                    NE;
    logic                    ZE;
    logic                    VE;
    logic                    CE;
    logic [ALUCTRLWIDTH-1:0] aluControlE;
    logic                    data2SelectorE;
    logic                    takeBranchE;
    logic                    flushFD;
    logic                    writeDataEnableM;
    logic                    resultSelectorM;
    logic                    outFlagM;
    logic                    writeEnableM;
    logic                    writeEnableW;
    logic                    resultSelectorW;
    logic [3:0]              flagsQ;

    modport master (
        output stallE, flushE, validD, opcodeD, writeEnableDD, writeDataEnableMD,
               resultSelectorWBD, data2SelectorED, outFlagD, aluControlED,
               NE, ZE, VE, CE,
        input  aluControlE, data2SelectorE, takeBranchE, flushFD, writeDataEnableM,
               resultSelectorM, outFlagM, writeEnableM, writeEnableW, resultSelectorW,
               flagsQ
    );

    modport slave (
        input  stallE, flushE, validD, opcodeD, writeEnableDD, writeDataEnableMD,
               resultSelectorWBD, data2SelectorED, outFlagD, aluControlED,
               NE, ZE, VE, CE,
        output aluControlE, data2SelectorE, takeBranchE, flushFD, writeDataEnableM,
               resultSelectorM, outFlagM, writeEnableM, writeEnableW, resultSelectorW,
               flagsQ
    );
endinterface

// File: rtl/exec_control_pipe.sv
// rtl/exec_control_pipe.sv - E/M/W control pipeline, NZVC flag register and branch resolver
//
// Ports:
//   clk  : pipeline clock, rising edge
//   rstN : asynchronous active-low reset; all stages become bubbles, flags clear
//   bus  : exec_control_pipe_if.slave - decode control word and hazard controls in,
//          Execute/Memory/Writeback controls, takeBranchE/flushFD and flagsQ out
module exec_control_pipe #(
    parameter int OPCODEWIDTH  = 4,
    parameter int ALUCTRLWIDTH = 3
) (
    input  logic               clk,
    input  logic               rstN,
    exec_control_pipe_if.slave bus
);
    localparam logic [OPCODEWIDTH-1:0] OP_CMP = OPCODEWIDTH'(4'b1010);
    localparam logic [OPCODEWIDTH-1:0] OP_B   = OPCODEWIDTH'(4'b1011);
    localparam logic [OPCODEWIDTH-1:0] OP_BEQ = OPCODEWIDTH'(4'b1100);
    localparam logic [OPCODEWIDTH-1:0] OP_BNE = OPCODEWIDTH'(4'b1101);
    localparam logic [OPCODEWIDTH-1:0] OP_BLT = OPCODEWIDTH'(4'b1110);
    localparam logic [OPCODEWIDTH-1:0] OP_BGE = OPCODEWIDTH'(4'b1111);

    typedef struct packed {
        logic                    valid;
        logic [OPCODEWIDTH-1:0]  opcode;
        logic                    write_enable;
        logic                    write_data_enable;
        logic                    result_selector;
        logic                    data2_selector;
        logic                    out_flag;
        logic [ALUCTRLWIDTH-1:0] alu_control;
    } e_word_t;

    typedef struct packed {
        logic valid;
        logic write_enable;
        logic write_data_enable;
        logic result_selector;
        logic out_flag;
    } m_word_t;

    typedef struct packed {
        logic valid;
        logic write_enable;
        logic result_selector;
    } w_word_t;

    e_word_t    d_word;
    e_word_t    e_q;
    m_word_t    m_q;
    w_word_t    w_q;
    logic [3:0] flags_q;
    logic       branch_cond;
    logic       take_branch;

    // A decode slot without a real instruction loads as an all-zero bubble.
    always_comb begin
        d_word = '0;
        if (bus.validD) begin
            d_word.valid             = 1'b1;
            d_word.opcode            = bus.opcodeD;
            d_word.write_enable      = bus.writeEnableDD;
            d_word.write_data_enable = bus.writeDataEnableMD;
            d_word.result_selector   = bus.resultSelectorWBD;
            d_word.data2_selector    = bus.data2SelectorED;
            d_word.out_flag          = bus.outFlagD;
            d_word.alu_control       = bus.aluControlED;
        end
    end

    // flags_q is {N,Z,V,C}; non-branch opcodes never satisfy the condition.
    always_comb begin
        branch_cond = 1'b0;
        case (e_q.opcode)
            OP_B:    branch_cond = 1'b1;
            OP_BEQ:  branch_cond = flags_q[2];
            OP_BNE:  branch_cond = !flags_q[2];
            OP_BLT:  branch_cond = flags_q[3] != flags_q[1];
            OP_BGE:  branch_cond = flags_q[3] == flags_q[1];
            default: branch_cond = 1'b0;
        endcase
    end

    // A stalled branch must not redirect yet; it fires on the first free cycle.
    assign take_branch = e_q.valid & !bus.stallE & branch_cond;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            e_q <= '0;
        end else if (take_branch || bus.flushE) begin
            // The taken branch squashes the wrong-path instruction now in decode.
            e_q <= '0;
        end else if (!bus.stallE) begin
            e_q <= d_word;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            m_q <= '0;
        end else if (bus.stallE) begin
            // The held E instruction must not also advance into M.
            m_q <= '0;
        end else begin
            m_q.valid             <= e_q.valid;
            m_q.write_enable      <= e_q.write_enable;
            m_q.write_data_enable <= e_q.write_data_enable;
            m_q.result_selector   <= e_q.result_selector;
            m_q.out_flag          <= e_q.out_flag;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            w_q <= '0;
        end else begin
            w_q.valid           <= m_q.valid;
            w_q.write_enable    <= m_q.write_enable;
            w_q.result_selector <= m_q.result_selector;
        end
    end

    // Updating at the compare's own edge lets a branch right behind it see the new flags.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            flags_q <= 4'b0000;
        end else if (e_q.valid && !bus.stallE && (e_q.opcode == OP_CMP)) begin
            flags_q <= {bus.NE, bus.ZE, bus.VE, bus.CE};
        end
    end

    assign bus.aluControlE      = e_q.alu_control;
    assign bus.data2SelectorE   = e_q.data2_selector;
    assign bus.takeBranchE      = take_branch;
    assign bus.flushFD          = take_branch;
    assign bus.writeEnableM     = m_q.valid & m_q.write_enable;
    assign bus.writeDataEnableM = m_q.valid & m_q.write_data_enable;
    assign bus.resultSelectorM  = m_q.valid & m_q.result_selector;
    assign bus.outFlagM         = m_q.valid & m_q.out_flag;
    assign bus.writeEnableW     = w_q.valid & w_q.write_enable;
    assign bus.resultSelectorW  = w_q.valid & w_q.result_selector;
    assign bus.flagsQ           = flags_q;
endmodule

// File: tb/tb_exec_control_pipe.sv
// tb/tb_exec_control_pipe.sv - self-checking bench for exec_control_pipe
module tb_exec_control_pipe;
    logic clk = 1'b0;
    logic rstN = 1'b1;
    always #5 clk = ~clk;

    exec_control_pipe_if #(.OPCODEWIDTH(4), .ALUCTRLWIDTH(3)) bus_i ();

    exec_control_pipe #(.OPCODEWIDTH(4), .ALUCTRLWIDTH(3)) dut (
        .clk  (clk),
        .rstN (rstN),
        .bus  (bus_i)
    );

    typedef struct packed {
        logic       v;
        logic [3:0] op;
        logic       we;
        logic       wde;
        logic       rs;
        logic       d2s;
        logic       of;
        logic [2:0] alu;
        logic       stall;
        logic       flush;
        logic [3:0] nzvc;
    } stim_t;

    // {takeBranchE, flushFD, aluControlE, data2SelectorE, writeDataEnableM,
    //  resultSelectorM, outFlagM, writeEnableM, writeEnableW, resultSelectorW, flagsQ}
    wire [15:0] obs = {bus_i.takeBranchE, bus_i.flushFD, bus_i.aluControlE, bus_i.data2SelectorE,
                       bus_i.writeDataEnableM, bus_i.resultSelectorM, bus_i.outFlagM,
                       bus_i.writeEnableM, bus_i.writeEnableW, bus_i.resultSelectorW, bus_i.flagsQ};

    logic [15:0] exp_q[$];
    int vectors = 0;
    int errors  = 0;

    localparam stim_t IDLE = '0;

    function automatic stim_t ins(logic [3:0] op, logic we, logic rs, logic [2:0] alu);
        stim_t t = '0;
        t.v   = 1'b1;
        t.op  = op;
        t.we  = we;
        t.rs  = rs;
        t.alu = alu;
        return t;
    endfunction

    function automatic stim_t idle_f(logic [3:0] nzvc);
        stim_t t = '0;
        t.nzvc = nzvc;
        return t;
    endfunction

    function automatic logic [15:0] ex(logic tb, logic [2:0] alu, logic d2s, logic wdem, logic rsm,
                                       logic ofm, logic wem, logic wew, logic rsw, logic [3:0] fl);
        return {tb, tb, alu, d2s, wdem, rsm, ofm, wem, wew, rsw, fl};
    endfunction

    task automatic drv(input stim_t s);
        bus_i.validD            = s.v;
        bus_i.opcodeD           = s.op;
        bus_i.writeEnableDD     = s.we;
        bus_i.writeDataEnableMD = s.wde;
        bus_i.resultSelectorWBD = s.rs;
        bus_i.data2SelectorED   = s.d2s;
        bus_i.outFlagD          = s.of;
        bus_i.aluControlED      = s.alu;
        bus_i.stallE            = s.stall;
        bus_i.flushE            = s.flush;
        {bus_i.NE, bus_i.ZE, bus_i.VE, bus_i.CE} = s.nzvc;
    endtask

    task automatic do_reset();
        @(negedge clk);
        drv(IDLE);
        rstN = 1'b0;
        @(negedge clk);
        rstN = 1'b1;
    endtask

    task automatic test_reset();
        logic [15:0] want;
        drv(ins(4'b0000, 1'b1, 1'b1, 3'b111));
        #1 rstN = 1'b0;
        exp_q.push_back(16'h0000);
        #1;
        want = exp_q.pop_front();
        vectors++;
        if (obs !== want) begin
            errors++;
            $display("FAIL reset_async: got %h want %h", obs, want);
        end
        @(posedge clk);
        exp_q.push_back(16'h0000);
        #1;
        want = exp_q.pop_front();
        vectors++;
        if (obs !== want) begin
            errors++;
            $display("FAIL reset_held_edge: got %h want %h", obs, want);
        end
        @(negedge clk);
        drv(IDLE);
        rstN = 1'b1;
    endtask

    task automatic test_cmp_beq();
        stim_t       s[6];
        logic [15:0] e[6];
        logic [15:0] want;
        s[0] = ins(4'b1010, 1'b0, 1'b0, 3'b001);          e[0] = ex(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 4'b0000);
        s[1] = ins(4'b1100, 1'b0, 1'b0, 3'b000);
        s[1].nzvc = 4'b0100;                              e[1] = ex(0, 3'b001, 0, 0, 0, 0, 0, 0, 0, 4'b0000);
        s[2] = ins(4'b0000, 1'b1, 1'b1, 3'b010);          e[2] = ex(1, 3'b000, 0, 0, 0, 0, 0, 0, 0, 4'b0100);
        s[3] = idle_f(4'b1111);                           e[3] = ex(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 4'b0100);
        s[4] = idle_f(4'b1111);                           e[4] = ex(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 4'b0100);
        s[5] = idle_f(4'b1111);                           e[5] = ex(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 4'b0100);
        do_reset();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            drv(s[i]);
            exp_q.push_back(e[i]);
            #1;
            want = exp_q.pop_front();
            vectors++;
            if (obs !== want) begin
                errors++;
                $display("FAIL cmp_beq row %0d: got %h want %h", i, obs, want);
            end
        end
    endtask

    task automatic test_branch_conds();
        stim_t       s[9];
        logic [15:0] e[9];
        logic [15:0] want;
        s[0] = ins(4'b1010, 1'b0, 1'b0, 3'b001);          e[0] = ex(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 4'b0000);
        s[1] = ins(4'b1101, 1'b0, 1'b0, 3'b000);
        s[1].nzvc = 4'b0100;                              e[1] = ex(0, 3'b001, 0, 0, 0, 0, 0, 0, 0, 4'b0000);
        s[2] = ins(4'b1010, 1'b0, 1'b0, 3'b001);          e[2] = ex(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 4'b0100);
        s[3] = ins(4'b1110, 1'b0, 1'b0, 3'b000);
        s[3].nzvc = 4'b1000;                              e[3] = ex(0, 3'b001, 0, 0, 0, 0, 0, 0, 0, 4'b0100);
        s[4] = IDLE;                                      e[4] = ex(1, 3'b000, 0, 0, 0, 0, 0, 0, 0, 4'b1000);
        s[5] = ins(4'b1010, 1'b0, 1'b0, 3'b001);          e[5] = ex(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 4'b1000);
        s[6] = ins(4'b1111, 1'b0, 1'b0, 3'b000);
        s[6].nzvc = 4'b1010;                              e[6] = ex(0, 3'b001, 0, 0, 0, 0, 0, 0, 0, 4'b1000);
        s[7] = IDLE;                                      e[7] = ex(1, 3'b000, 0, 0, 0, 0, 0, 0, 0, 4'b1010);
        s[8] = IDLE;                                      e[8] = ex(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 4'b1010);
        do_reset();
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            drv(s[i]);
            exp_q.push_back(e[i]);
            #1;
            want = exp_q.pop_front();
            vectors++;
            if (obs !== want) begin
                errors++;
                $display("FAIL branch_conds row %0d: got %h want %h", i, obs, want);
            end
        end
    endtask

    task automatic test_stall_hold();
        stim_t       s[8];
        logic [15:0] e[8];
        logic [15:0] want;
        s[0] = ins(4'b0000, 1'b1, 1'b1, 3'b101);
        s[0].wde = 1'b1;
        s[0].d2s = 1'b1;
        s[0].of  = 1'b1;                                  e[0] = ex(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 4'b0000);
        s[1] = ins(4'b0001, 1'b1, 1'b0, 3'b011);
        s[1].stall = 1'b1;                                e[1] = ex(0, 3'b101, 1, 0, 0, 0, 0, 0, 0, 4'b0000);
        s[2] = s[1];                                      e[2] = ex(0, 3'b101, 1, 0, 0, 0, 0, 0, 0, 4'b0000);
        s[3] = ins(4'b0001, 1'b1, 1'b0, 3'b011);          e[3] = ex(0, 3'b101, 1, 0, 0, 0, 0, 0, 0, 4'b0000);
        s[4] = IDLE;                                      e[4] = ex(0, 3'b011, 0, 1, 1, 1, 1, 0, 0, 4'b0000);
        s[5] = IDLE;                                      e[5] = ex(0, 3'b000, 0, 0, 0, 0, 1, 1, 1, 4'b0000);
        s[6] = IDLE;                                      e[6] = ex(0, 3'b000, 0, 0, 0, 0, 0, 1, 0, 4'b0000);
        s[7] = IDLE;                                      e[7] = ex(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 4'b0000);
        do_reset();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            drv(s[i]);
            exp_q.push_back(e[i]);
            #1;
            want = exp_q.pop_front();
            vectors++;
            if (obs !== want) begin
                errors++;
                $display("FAIL stall_hold row %0d: got %h want %h", i, obs, want);
            end
        end
    endtask

    task automatic test_stalled_branch();
        stim_t       s[8];
        logic [15:0] e[8];
        logic [15:0] want;
        s[0] = ins(4'b1011, 1'b0, 1'b0, 3'b000);          e[0] = ex(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 4'b0000);
        s[1] = ins(4'b0000, 1'b1, 1'b0, 3'b010);
        s[1].stall = 1'b1;                                e[1] = ex(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 4'b0000);
        s[2] = s[1];                                      e[2] = ex(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 4'b0000);
        s[3] = s[1];                                      e[3] = ex(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 4'b0000);
        s[4] = ins(4'b0000, 1'b1, 1'b0, 3'b010);          e[4] = ex(1, 3'b000, 0, 0, 0, 0, 0, 0, 0, 4'b0000);
        s[5] = IDLE;                                      e[5] = ex(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 4'b0000);
        s[6] = IDLE;                                      e[6] = ex(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 4'b0000);
        s[7] = IDLE;                                      e[7] = ex(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 4'b0000);
        do_reset();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            drv(s[i]);
            exp_q.push_back(e[i]);
            #1;
            want = exp_q.pop_front();
            vectors++;
            if (obs !== want) begin
                errors++;
                $display("FAIL stalled_branch row %0d: got %h want %h", i, obs, want);
            end
        end
    endtask

    task automatic test_flush_stall();
        stim_t       s[7];
        logic [15:0] e[7];
        logic [15:0] want;
        s[0] = ins(4'b1010, 1'b0, 1'b0, 3'b001);          e[0] = ex(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 4'b0000);
        s[1] = idle_f(4'b0110);                           e[1] = ex(0, 3'b001, 0, 0, 0, 0, 0, 0, 0, 4'b0000);
        s[2] = ins(4'b0011, 1'b1, 1'b1, 3'b110);
        s[2].stall = 1'b1;
        s[2].flush = 1'b1;                                e[2] = ex(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 4'b0110);
        s[3] = ins(4'b1010, 1'b0, 1'b0, 3'b001);
        s[3].flush = 1'b1;
        s[3].nzvc  = 4'b1111;                             e[3] = ex(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 4'b0110);
        s[4] = idle_f(4'b1111);                           e[4] = ex(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 4'b0110);
        s[5] = idle_f(4'b1111);                           e[5] = ex(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 4'b0110);
        s[6] = idle_f(4'b1111);                           e[6] = ex(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 4'b0110);
        do_reset();
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            drv(s[i]);
            exp_q.push_back(e[i]);
            #1;
            want = exp_q.pop_front();
            vectors++;
            if (obs !== want) begin
                errors++;
                $display("FAIL flush_stall row %0d: got %h want %h", i, obs, want);
            end
        end
    endtask

    task automatic test_reset_midstream();
        stim_t       s[4];
        logic [15:0] e[4];
        logic [15:0] want;
        s[0] = ins(4'b1010, 1'b0, 1'b0, 3'b001);          e[0] = ex(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 4'b0000);
        s[1] = ins(4'b0001, 1'b1, 1'b0, 3'b010);
        s[1].nzvc = 4'b1001;                              e[1] = ex(0, 3'b001, 0, 0, 0, 0, 0, 0, 0, 4'b0000);
        s[2] = ins(4'b0010, 1'b1, 1'b1, 3'b011);          e[2] = ex(0, 3'b010, 0, 0, 0, 0, 0, 0, 0, 4'b1001);
        s[3] = ins(4'b0100, 1'b1, 1'b0, 3'b100);          e[3] = ex(0, 3'b011, 0, 0, 0, 0, 1, 0, 0, 4'b1001);
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drv(s[i]);
            exp_q.push_back(e[i]);
            #1;
            want = exp_q.pop_front();
            vectors++;
            if (obs !== want) begin
                errors++;
                $display("FAIL reset_mid row %0d: got %h want %h", i, obs, want);
            end
        end
        @(negedge clk);
        drv(ins(4'b0101, 1'b1, 1'b1, 3'b111));
        exp_q.push_back(ex(0, 3'b100, 0, 0, 1, 0, 1, 1, 0, 4'b1001));
        #1;
        want = exp_q.pop_front();
        vectors++;
        if (obs !== want) begin
            errors++;
            $display("FAIL reset_mid_inflight: got %h want %h", obs, want);
        end
        rstN = 1'b0;
        exp_q.push_back(16'h0000);
        #1;
        want = exp_q.pop_front();
        vectors++;
        if (obs !== want) begin
            errors++;
            $display("FAIL reset_mid_async: got %h want %h", obs, want);
        end
        #2 rstN = 1'b1;
        @(posedge clk);
        exp_q.push_back(ex(0, 3'b111, 0, 0, 0, 0, 0, 0, 0, 4'b0000));
        #1;
        want = exp_q.pop_front();
        vectors++;
        if (obs !== want) begin
            errors++;
            $display("FAIL reset_mid_resume: got %h want %h", obs, want);
        end
        @(negedge clk);
        drv(IDLE);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        drv(IDLE);
        test_reset();
        test_cmp_beq();
        test_branch_conds();
        test_stall_hold();
        test_stalled_branch();
        test_flush_stall();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
